// File: rtl/alu_result_collector_pkg.sv
// Shared definitions for the ALU result collector.
// Holds the result source unit codes and the default operand/result widths
// that the ALU top reuses when it instantiates the collector.
package alu_result_collector_pkg;

  localparam int ARITH_OUT_WIDTH_DEF = 32;
  localparam int LOGIC_OUT_WIDTH_DEF = 16;
  localparam int SHIFT_OUT_WIDTH_DEF = 16;
  localparam int CMP_OUT_WIDTH_DEF   = 2;
  localparam int FIFO_DEPTH_DEF      = 4;

  localparam int UNIT_W = 2;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

endpackage

// File: rtl/alu_result_collector_result_fifo.sv
// result_fifo: first-word-fall-through buffer for collected ALU results.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i, wdata_i  write request and data (taken when not full, or when a
//                    pop happens on the same edge)
//   pop_i          remove head (ignored when empty)
//   rdata_o        head entry, zero when empty
//   full_o, empty_o, count_o  occupancy status
module result_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;

  // A full buffer still accepts a write when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the occupancy counter alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: gathers results from the arithmetic, logic, compare
// and shift units into one tagged stream for a downstream consumer.
// Ports:
//   CLK, RST                  clock, asynchronous active-low reset
//   *_OUT / *_Flag            per-unit result and its valid strobe
//   res_valid/res_ready       head handshake; res_data/res_unit head entry
//   res_count                 buffered entries
//   ovf_err, multi_err        sticky errors (drop on full, >1 strobe per cycle)
//   err_clr                   synchronous clear of both sticky errors
module alu_result_collector
  import alu_result_collector_pkg::*;
#(
  parameter int ARITH_OUT_WIDTH = ARITH_OUT_WIDTH_DEF,
  parameter int LOGIC_OUT_WIDTH = LOGIC_OUT_WIDTH_DEF,
  parameter int SHIFT_OUT_WIDTH = SHIFT_OUT_WIDTH_DEF,
  parameter int CMP_OUT_WIDTH   = CMP_OUT_WIDTH_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [ARITH_OUT_WIDTH-1:0]    Arith_OUT,
  input  logic                          Arith_Flag,
  input  logic [LOGIC_OUT_WIDTH-1:0]    Logic_OUT,
  input  logic                          Logic_Flag,
  input  logic [CMP_OUT_WIDTH-1:0]      CMP_OUT,
  input  logic                          CMP_Flag,
  input  logic [SHIFT_OUT_WIDTH-1:0]    SHIFT_OUT,
  input  logic                          SHIFT_Flag,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ARITH_OUT_WIDTH-1:0]    res_data,
  output logic [1:0]                    res_unit,
  output logic [$clog2(FIFO_DEPTH):0]   res_count,
  output logic                          ovf_err,
  output logic                          multi_err,
  input  logic                          err_clr
);

  localparam int ENTRY_W = UNIT_W + ARITH_OUT_WIDTH;

  logic [ARITH_OUT_WIDTH-1:0] sel_data;
  unit_e                      sel_unit;
  logic                       cap_valid;
  logic [2:0]                 flag_cnt;
  logic                       ovf_evt, multi_evt;
  logic                       ovf_q, ovf_d, multi_q, multi_d;
  logic                       pop;
  logic                       fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]         fifo_rdata;

  assign cap_valid = Arith_Flag | Logic_Flag | CMP_Flag | SHIFT_Flag;
  assign flag_cnt  = 3'(Arith_Flag) + 3'(Logic_Flag) + 3'(CMP_Flag) + 3'(SHIFT_Flag);

  // Fixed priority when several units report together; narrow results are
  // zero-extended so the consumer sees them as unsigned.
  always_comb begin
    sel_data = '0;
    sel_unit = UNIT_ARITH;
    if (Arith_Flag) begin
      sel_data = Arith_OUT;
    end else if (Logic_Flag) begin
      sel_data[LOGIC_OUT_WIDTH-1:0] = Logic_OUT;
      sel_unit = UNIT_LOGIC;
    end else if (CMP_Flag) begin
      sel_data[CMP_OUT_WIDTH-1:0] = CMP_OUT;
      sel_unit = UNIT_CMP;
    end else if (SHIFT_Flag) begin
      sel_data[SHIFT_OUT_WIDTH-1:0] = SHIFT_OUT;
      sel_unit = UNIT_SHIFT;
    end
  end

  assign pop       = !fifo_empty && res_ready;
  assign ovf_evt   = cap_valid && fifo_full && !pop;
  assign multi_evt = (flag_cnt > 3'd1);

  // A fresh error on the clearing edge keeps the bit set.
  assign ovf_d   = (ovf_q   && !err_clr) || ovf_evt;
  assign multi_d = (multi_q && !err_clr) || multi_evt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      multi_q <= multi_d;
    end
  end

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (cap_valid),
    .wdata_i ({sel_unit, sel_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (res_count)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_rdata[ARITH_OUT_WIDTH-1:0];
  assign res_unit  = fifo_rdata[ENTRY_W-1:ARITH_OUT_WIDTH];
  assign ovf_err   = ovf_q;
  assign multi_err = multi_q;

endmodule
